// File: rtl/md_defs_pkg.sv
// Shared MD-unit definitions: operation encodings, scheduler states, default latencies.
// Pure declarations, no timing or flow-control behaviour of its own.
package md_defs_pkg;

    typedef enum logic [2:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6,
        MD_RSVD  = 3'd7
    } md_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } md_state_e;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
    } md_res_t;

    localparam int unsigned MD_MULT_CYCLES_DEF = 5;
    localparam int unsigned MD_DIV_CYCLES_DEF  = 10;
    localparam int unsigned MD_CNT_W           = 4;

    function automatic logic md_is_arith(input logic [2:0] op);
        return (op >= 3'd1) && (op <= 3'd4);
    endfunction

    function automatic logic md_is_write(input logic [2:0] op);
        return (op >= 3'd1) && (op <= 3'd6);
    endfunction

endpackage

// File: rtl/md_arith.sv
// Combinational 64-bit product / quotient-remainder unit on the latched operands.
// Zero latency, no flow control; the scheduler decides when the result is consumed.
module md_arith
    import md_defs_pkg::*;
(
    input  logic [2:0]  op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output md_res_t     res_o,
    output logic        div_zero_o
);

    logic        is_signed;
    logic        neg_a;
    logic        neg_b;
    logic [63:0] a_ext;
    logic [63:0] b_ext;
    logic [63:0] prod;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] q_mag;
    logic [31:0] r_mag;

    // Division runs on magnitudes so 0x80000000 / -1 wraps cleanly instead of overflowing.
    always_comb begin
        is_signed  = (op_i == MD_MULT) || (op_i == MD_DIV);
        neg_a      = is_signed & a_i[31];
        neg_b      = is_signed & b_i[31];
        a_ext      = {{32{neg_a}}, a_i};
        b_ext      = {{32{neg_b}}, b_i};
        prod       = a_ext * b_ext;
        a_mag      = neg_a ? (~a_i + 32'd1) : a_i;
        b_mag      = neg_b ? (~b_i + 32'd1) : b_i;
        div_zero_o = (b_i == 32'd0);
        q_mag      = div_zero_o ? 32'd0 : (a_mag / b_mag);
        r_mag      = div_zero_o ? 32'd0 : (a_mag % b_mag);
        res_o      = '0;
        if ((op_i == MD_MULT) || (op_i == MD_MULTU)) begin
            res_o = prod;
        end else begin
            res_o.lo = (neg_a ^ neg_b) ? (~q_mag + 32'd1) : q_mag;
            res_o.hi = neg_a ? (~r_mag + 32'd1) : r_mag;
        end
    end

endmodule

// File: rtl/md_scheduler.sv
// HI/LO multiply/divide scheduler: arithmetic ops busy for MULT_CYCLES/DIV_CYCLES then commit; mthi/mtlo write at issue.
// No input backpressure: D stage is held off through stall_md_o, and starts arriving while busy are dropped.
module md_scheduler
    import md_defs_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MD_MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [2:0]  md_op_i,
    input  logic        md_start_i,
    input  logic [31:0] src_a_i,
    input  logic [31:0] src_b_i,
    input  logic        d_md_i,
    output logic        busy_o,
    output logic        stall_md_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    localparam logic [MD_CNT_W-1:0] MULT_LD = MD_CNT_W'(MULT_CYCLES);
    localparam logic [MD_CNT_W-1:0] DIV_LD  = MD_CNT_W'(DIV_CYCLES);

    md_state_e           state_q, state_d;
    logic [MD_CNT_W-1:0] cnt_q, cnt_d;
    md_op_e              op_q;
    logic [31:0]         a_q, b_q;
    logic [31:0]         hi_q, hi_d;
    logic [31:0]         lo_q, lo_d;

    logic                idle;
    logic                arith_issue;
    logic                mt_issue;
    logic                commit;
    logic                div_zero;
    md_res_t             arith_res;

    assign idle        = (state_q == ST_IDLE);
    assign arith_issue = md_start_i & md_is_arith(md_op_i) & idle;
    assign mt_issue    = md_start_i & ((md_op_i == MD_MTHI) || (md_op_i == MD_MTLO)) & idle;
    assign commit      = (state_q == ST_RUN) && (cnt_q == MD_CNT_W'(1));

    md_arith u_arith (
        .op_i       (op_q),
        .a_i        (a_q),
        .b_i        (b_q),
        .res_o      (arith_res),
        .div_zero_o (div_zero)
    );

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (arith_issue) state_d = ST_RUN;
            ST_RUN:  if (cnt_q == MD_CNT_W'(1)) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy_o     = (state_q == ST_RUN);
        stall_md_o = d_md_i & (busy_o | (md_start_i & md_is_write(md_op_i)));
    end

    // Divide by zero burns the full latency but leaves HI/LO untouched.
    always_comb begin
        cnt_d = cnt_q;
        hi_d  = hi_q;
        lo_d  = lo_q;
        if (arith_issue) begin
            cnt_d = ((md_op_i == MD_MULT) || (md_op_i == MD_MULTU)) ? MULT_LD : DIV_LD;
        end else if (state_q == ST_RUN) begin
            cnt_d = cnt_q - MD_CNT_W'(1);
        end
        if (commit && !(div_zero && ((op_q == MD_DIV) || (op_q == MD_DIVU)))) begin
            hi_d = arith_res.hi;
            lo_d = arith_res.lo;
        end
        if (mt_issue) begin
            if (md_op_i == MD_MTHI) begin
                hi_d = src_a_i;
            end else begin
                lo_d = src_a_i;
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            cnt_q <= '0;
            op_q  <= MD_NONE;
            a_q   <= '0;
            b_q   <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            if (arith_issue) begin
                op_q <= md_op_e'(md_op_i);
                a_q  <= src_a_i;
                b_q  <= src_b_i;
            end
        end
    end

    assign hi_o = hi_q;
    assign lo_o = lo_q;

endmodule

// File: tb/tb_md_scheduler.sv
// Randomised scoreboard bench for md_scheduler against a plain-arithmetic HI/LO model.
module tb_md_scheduler;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  md_op;
    logic        md_start;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        d_md;
    logic        busy;
    logic        stall_md;
    logic [31:0] hi;
    logic [31:0] lo;

    always #5 clk = ~clk;

    md_scheduler #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk_i      (clk),
        .reset_i    (reset),
        .md_op_i    (md_op),
        .md_start_i (md_start),
        .src_a_i    (src_a),
        .src_b_i    (src_b),
        .d_md_i     (d_md),
        .busy_o     (busy),
        .stall_md_o (stall_md),
        .hi_o       (hi),
        .lo_o       (lo)
    );

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
    } txn_t;

    typedef struct {
        logic busy;
        logic stall;
    } cyc_t;

    txn_t        txn_q[$];
    cyc_t        cyc_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] m_hi     = '0;
    logic [31:0] m_lo     = '0;
    int          rem      = 0;

    logic        mon_prev_busy;
    int          mon_bcnt;
    logic        mon_mt_pend;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, want %0h", name, act, exp);
    endtask

    // Expected HI/LO from the architectural rules, using 64-bit integer arithmetic.
    function automatic txn_t ref_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        txn_t        t;
        longint      sa, sb;
        longint      ua, ub;
        logic [63:0] p, q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        t.hi  = m_hi;
        t.lo  = m_lo;
        t.lat = (op <= 3'd2) ? MC : DC;
        case (op)
            3'd1: begin p = 64'(sa * sb); t.hi = p[63:32]; t.lo = p[31:0]; end
            3'd2: begin p = 64'(ua * ub); t.hi = p[63:32]; t.lo = p[31:0]; end
            3'd3: if (b != 0) begin q = 64'(sa / sb); r = 64'(sa % sb); t.lo = q[31:0]; t.hi = r[31:0]; end
            3'd4: if (b != 0) begin q = 64'(ua / ub); r = 64'(ua % ub); t.lo = q[31:0]; t.hi = r[31:0]; end
            default: ;
        endcase
        return t;
    endfunction

    task automatic cycle(input logic st, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic dm);
        cyc_t c;
        txn_t t;
        md_start = st;
        md_op    = op;
        src_a    = a;
        src_b    = b;
        d_md     = dm;
        c.busy   = (rem > 0);
        c.stall  = dm & (c.busy | (st & (op inside {[1:6]})));
        cyc_q.push_back(c);
        if (rem > 0) begin
            rem--;
        end else if (st && (op inside {[1:4]})) begin
            t = ref_op(op, a, b);
            txn_q.push_back(t);
            m_hi = t.hi;
            m_lo = t.lo;
            rem  = t.lat;
        end else if (st && (op inside {[5:6]})) begin
            if (op == 3'd5) m_hi = a;
            else            m_lo = a;
            t.hi  = m_hi;
            t.lo  = m_lo;
            t.lat = 0;
            txn_q.push_back(t);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic op_wait(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic dm);
        cycle(1'b1, op, a, b, dm);
        while (rem > 0) cycle(1'b0, 3'd0, 32'd0, 32'd0, dm);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // Monitor: per-cycle busy/stall, plus HI/LO and latency whenever an operation completes.
    initial begin : monitor
        cyc_t c;
        txn_t t;
        mon_prev_busy = 1'b0;
        mon_bcnt      = 0;
        mon_mt_pend   = 1'b0;
        forever begin
            @(negedge clk);
            if (mon_mt_pend) begin
                mon_mt_pend = 1'b0;
                if (txn_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL mt_no_txn: write seen with empty scoreboard");
                end else begin
                    t = txn_q.pop_front();
                    chk("mt_hi", 64'(hi), 64'(t.hi));
                    chk("mt_lo", 64'(lo), 64'(t.lo));
                end
            end
            if (cyc_q.size() > 0) begin
                c = cyc_q.pop_front();
                chk("busy", 64'(busy), 64'(c.busy));
                chk("stall_md", 64'(stall_md), 64'(c.stall));
            end
            if (!reset) begin
                if (busy) begin
                    mon_bcnt++;
                end else if (mon_prev_busy) begin
                    if (txn_q.size() == 0) begin
                        n_checks++;
                        $display("FAIL unexpected_commit: busy fell with empty scoreboard");
                    end else begin
                        t = txn_q.pop_front();
                        chk("commit_hi", 64'(hi), 64'(t.hi));
                        chk("commit_lo", 64'(lo), 64'(t.lo));
                        chk("busy_cycles", 64'(mon_bcnt), 64'(t.lat));
                    end
                    mon_bcnt = 0;
                end
                if (md_start && (md_op inside {[5:6]}) && !busy) mon_mt_pend = 1'b1;
            end else begin
                mon_bcnt = 0;
            end
            mon_prev_busy = busy;
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        logic [2:0] op;
        reset    = 1'b1;
        md_start = 1'b0;
        md_op    = 3'd0;
        src_a    = '0;
        src_b    = '0;
        d_md     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_hi", 64'(hi), 64'd0);
        chk("rst_lo", 64'(lo), 64'd0);
        reset = 1'b0;

        // Reset in the middle of a multiply: result must be discarded.
        cycle(1'b1, 3'd5, 32'hA5A5_0001, 32'd0, 1'b0);
        cycle(1'b1, 3'd6, 32'h5A5A_0002, 32'd0, 1'b0);
        cycle(1'b1, 3'd1, 32'd3, 32'd4, 1'b0);
        cycle(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
        cycle(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
        reset = 1'b1;
        #1;
        chk("midrun_rst_busy", 64'(busy), 64'd0);
        chk("midrun_rst_hi", 64'(hi), 64'd0);
        chk("midrun_rst_lo", 64'(lo), 64'd0);
        txn_q.delete();
        rem  = 0;
        m_hi = '0;
        m_lo = '0;
        cycle(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
        reset = 1'b0;
        repeat (8) cycle(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
        chk("no_commit_hi", 64'(hi), 64'd0);
        chk("no_commit_lo", 64'(lo), 64'd0);

        op_wait(3'd1, 32'hFFFF_FFFF, 32'd2, 1'b1);
        chk("mult_hi", 64'(hi), 64'hFFFF_FFFF);
        chk("mult_lo", 64'(lo), 64'hFFFF_FFFE);
        cycle(1'b0, 3'd0, 32'd0, 32'd0, 1'b1);

        op_wait(3'd2, 32'hFFFF_FFFF, 32'd2, 1'b0);
        chk("multu_hi", 64'(hi), 64'h0000_0001);
        chk("multu_lo", 64'(lo), 64'hFFFF_FFFE);

        op_wait(3'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);
        chk("div_hi", 64'(hi), 64'hFFFF_FFFF);
        chk("div_lo", 64'(lo), 64'hFFFF_FFFD);

        cycle(1'b1, 3'd5, 32'h11, 32'd0, 1'b0);
        cycle(1'b1, 3'd6, 32'h22, 32'd0, 1'b0);
        op_wait(3'd4, 32'd7, 32'd0, 1'b0);
        chk("divz_hi", 64'(hi), 64'h11);
        chk("divz_lo", 64'(lo), 64'h22);

        cycle(1'b1, 3'd5, 32'hDEAD_BEEF, 32'd0, 1'b1);
        chk("mthi_hi", 64'(hi), 64'hDEAD_BEEF);
        chk("mthi_busy", 64'(busy), 64'd0);
        cycle(1'b0, 3'd0, 32'd0, 32'd0, 1'b1);

        op_wait(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        chk("divovf_hi", 64'(hi), 64'd0);
        chk("divovf_lo", 64'(lo), 64'h8000_0000);

        // A start arriving mid-divide is dropped; the divide still commits on time.
        cycle(1'b1, 3'd3, 32'd100, 32'd7, 1'b0);
        cycle(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
        cycle(1'b1, 3'd1, 32'h0001_2345, 32'h0000_0777, 1'b1);
        while (rem > 0) cycle(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
        chk("ignored_hi", 64'(hi), 64'd2);
        chk("ignored_lo", 64'(lo), 64'd14);

        for (int i = 0; i < 150; i++) begin
            repeat ($urandom_range(0, 3))
                cycle(1'b0, 3'($urandom_range(0, 7)), $urandom, $urandom, 1'($urandom_range(0, 1)));
            op = 3'($urandom_range(0, 7));
            cycle(1'b1, op, pick(), pick(), 1'($urandom_range(0, 1)));
            while (rem > 0)
                cycle(1'b0, 3'($urandom_range(0, 7)), $urandom, $urandom, 1'($urandom_range(0, 1)));
        end

        repeat (3) cycle(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
        chk("txn_q_drained", 64'(txn_q.size()), 64'd0);
        chk("cyc_q_drained", 64'(cyc_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/md_scheduler.md
Name: md_scheduler

Overview:
- Sequences the multi-cycle multiply/divide resource (HI/LO) for the 5-stage pipeline.
- Accepts an MD operation from the E stage. Holds the unit busy for a fixed latency, then commits the result to HI/LO.
- Produces the D-stage stall request whenever a decoded MD instruction would collide with an in-flight or just-issued operation.
- Sits beside the E-stage ALU. Its hi/lo outputs feed the mfhi/mflo result mux.

Parameters:
MULT_CYCLES, 5, busy cycles for mult/multu (legal range 1..15)
DIV_CYCLES, 10, busy cycles for div/divu (legal range 1..15)

Ports:
clk  input  1  single system clock, rising edge
reset  input  1  asynchronous, active-high reset
md_op  input  3  E-stage MD operation: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none)
md_start  input  1  E-stage instruction is valid and md_op is to be issued this cycle
src_a  input  32  E-stage forwarded rs value
src_b  input  32  E-stage forwarded rt value
d_md  input  1  D-stage instruction is any MD-class instruction (mult..mtlo, mfhi, mflo)
busy  output  1  an arithmetic operation is in flight
stall_md  output  1  stall request to the hazard unit (combinational)
hi  output  32  HI register
lo  output  32  LO register

Behaviour:
- Reset (asynchronous, any time including mid-operation): hi=0, lo=0, busy=0, counter=0, state=IDLE. The in-flight result is discarded.
- States: IDLE and RUN. busy is 1 exactly when state=RUN.
- Issue condition: arith_issue = md_start & md_op in {1..4} & state==IDLE.
- IDLE, arith_issue at edge E0:
  - latch src_a/src_b and the op.
  - load counter with MULT_CYCLES (ops 1/2) or DIV_CYCLES (ops 3/4).
  - go to RUN.
- RUN, each edge:
  - counter decrements.
  - at the edge where counter==1: commit the result, go to IDLE, busy=0.
  - busy is therefore high for exactly N cycles after E0. New hi/lo are visible from edge E0+N.
- mthi/mtlo (ops 5/6) with md_start in IDLE: hi (or lo) <= src_a at that edge. Zero latency, busy stays 0.
- md_start while RUN: ignored entirely; operands and HI/LO are unaffected. stall_md guarantees this never happens in-system, and the bench asserts it.
- Arithmetic rules:
  - mult: {hi,lo} = signed 64-bit product.
  - multu: {hi,lo} = unsigned 64-bit product.
  - div: lo = quotient truncated toward zero; hi = remainder with the sign of the dividend.
  - divu: unsigned quotient and remainder.
  - div 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
  - Divide by zero: full DIV_CYCLES busy, then hi/lo unchanged.
- stall_md = d_md & (busy | (md_start & md_op in {1..6})). Purely combinational, no reset dependence beyond busy.
  - mthi/mtlo in E stalls a D-stage MD instruction for one cycle, so mfhi/mflo never read a stale value (no HI/LO forwarding path exists).
- hi/lo outputs change only at commit, mthi/mtlo, or reset. During RUN they hold their prior values.

Decomposition:
- Shared package/header md_defs: md_op encodings (MD_NONE..MD_MTLO) and default latencies.
- One sub-module is natural: md_arith, a combinational 64-bit product / quotient-remainder unit fed by the latched operands. The scheduler owns the FSM, counter, HI/LO and stall.

Test Plan:
- Reset then idle: reset=1 mid-run (counter=3) -> busy=0, hi=lo=0 immediately, with no commit on the next edges.
- mult 0xFFFFFFFF x 2 at E0 -> busy=1 for 5 cycles; at E0+5 hi=0xFFFFFFFF, lo=0xFFFFFFFE. multu with the same operands -> hi=0x00000001, lo=0xFFFFFFFE.
- div -7 / 2 -> after 10 busy cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu 7 / 0 with hi=0x11, lo=0x22 beforehand -> 10 busy cycles, then hi=0x11, lo=0x22.
- Stall: mult issued with d_md=1 in the same cycle -> stall_md=1 that cycle and for the next 5 cycles, 0 after. With d_md=0 -> stall_md=0 throughout.
- mthi 0xDEADBEEF issued while d_md=1 -> stall_md=1 that cycle only; next cycle hi=0xDEADBEEF, busy=0.
- md_start with mult while RUN from an earlier div -> ignored; the div result commits at the original cycle with the original operands.
